dataram_rsp_route: RTL and testbench

Response-side companion to the data RAM request arbiter. It takes the single granted command per cycle and drives the data RAM port. It tracks outstanding reads through the fixed RAM read latency and steers returned read data to one of two destinations: the upstream read-return channel or the eviction data channel toward downstream txdat. Per-destination credit counters guarantee that every issued read has a guaranteed buffer slot, so RAM data is never dropped.

---
 rtl/dataram_rsp_route_if.sv | 61 ++++++
 rtl/dataram_rsp_route.sv | 170 +++++++++++++++++
 tb/tb_dataram_rsp_route.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dataram_rsp_route_if.sv
// Bus bundle for dataram_rsp_route: command input, data RAM port and the two response channels.
// The parity ports exist only when DATARAM_RSP_PARITY_EN is defined.
interface dataram_rsp_route_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256,
  parameter int ID_W   = 6
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic              cmd_wr;
  logic              cmd_src;
  logic [ID_W-1:0]   cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              rd_rsp_vld;
  logic              rd_rsp_rdy;
  logic [DATA_W-1:0] rd_rsp_data;
  logic [ID_W-1:0]   rd_rsp_id;

  logic              ev_dat_vld;
  logic              ev_dat_rdy;
  logic [DATA_W-1:0] ev_dat_data;
  logic [ID_W-1:0]   ev_dat_id;

`ifdef DATARAM_RSP_PARITY_EN
  logic              ram_rpar;
  logic              rd_rsp_err;
  logic              ev_dat_err;
`endif

  modport slave (
`ifdef DATARAM_RSP_PARITY_EN
    input  ram_rpar,
    output rd_rsp_err, ev_dat_err,
`endif
    input  cmd_vld, cmd_wr, cmd_src, cmd_id, cmd_addr, cmd_wdata,
    input  ram_rdata, rd_rsp_rdy, ev_dat_rdy,
    output cmd_rdy, ram_en, ram_we, ram_addr, ram_wdata,
    output rd_rsp_vld, rd_rsp_data, rd_rsp_id,
    output ev_dat_vld, ev_dat_data, ev_dat_id
  );

  modport master (
`ifdef DATARAM_RSP_PARITY_EN
    output ram_rpar,
    input  rd_rsp_err, ev_dat_err,
`endif
    output cmd_vld, cmd_wr, cmd_src, cmd_id, cmd_addr, cmd_wdata,
    output ram_rdata, rd_rsp_rdy, ev_dat_rdy,
    input  cmd_rdy, ram_en, ram_we, ram_addr, ram_wdata,
    input  rd_rsp_vld, rd_rsp_data, rd_rsp_id,
    input  ev_dat_vld, ev_dat_data, ev_dat_id
  );
endinterface

// File: rtl/dataram_rsp_route.sv
// Drives the data RAM from the granted command and steers read data into per-destination FIFOs
// guarded by credits. Optional parity checking: define DATARAM_RSP_PARITY_EN. RSP_DEPTH: power of two >= 2.
module dataram_rsp_route #(
  parameter int RAM_LAT   = 2,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 6,
  parameter int RSP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  dataram_rsp_route_if.slave bus
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(RSP_DEPTH);

  logic              cmd_rdy, cmd_acc, rd_acc;
  logic [1:0]        inc, push, pop, out_vld, out_rdy;
  logic [CW-1:0]     cred_q [2];
  logic [CW-1:0]     cred_d [2];

  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic [RAM_LAT:0]  tag_vld_q, tag_vld_d, tag_src_q, tag_src_d;
  logic [ID_W-1:0]   tag_id_q [RAM_LAT+1];
  logic [ID_W-1:0]   tag_id_d [RAM_LAT+1];

  logic [PW-1:0]     wr_ptr_q [2];
  logic [PW-1:0]     wr_ptr_d [2];
  logic [PW-1:0]     rd_ptr_q [2];
  logic [PW-1:0]     rd_ptr_d [2];
  logic [DATA_W-1:0] fifo_data_q [2][RSP_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [2][RSP_DEPTH];
  logic [ID_W-1:0]   fifo_id_q [2][RSP_DEPTH];
  logic [ID_W-1:0]   fifo_id_d [2][RSP_DEPTH];
  logic [DATA_W-1:0] head_data [2];
  logic [ID_W-1:0]   head_id [2];

  // Reads only need a free credit at their own destination; writes never wait.
  always_comb begin
    cmd_rdy = bus.cmd_wr | (cred_q[bus.cmd_src] < CRED_MAX);
    cmd_acc = bus.cmd_vld & cmd_rdy;
    rd_acc  = cmd_acc & ~bus.cmd_wr;
    inc     = {rd_acc & bus.cmd_src, rd_acc & ~bus.cmd_src};
  end

  always_comb begin
    ram_en_d    = cmd_acc;
    ram_we_d    = cmd_acc & bus.cmd_wr;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (cmd_acc) begin
      ram_addr_d  = bus.cmd_addr;
      ram_wdata_d = bus.cmd_wdata;
    end
  end

  // Stage 0 runs alongside the RAM stage; stage RAM_LAT lines up with valid ram_rdata.
  always_comb begin
    tag_vld_d    = {tag_vld_q[RAM_LAT-1:0], rd_acc};
    tag_src_d    = {tag_src_q[RAM_LAT-1:0], bus.cmd_src};
    tag_id_d[0]  = bus.cmd_id;
    for (int k = 1; k <= RAM_LAT; k++) begin
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  always_comb begin
    out_rdy = {bus.ev_dat_rdy, bus.rd_rsp_rdy};
    push    = {tag_vld_q[RAM_LAT] & tag_src_q[RAM_LAT], tag_vld_q[RAM_LAT] & ~tag_src_q[RAM_LAT]};
    for (int s = 0; s < 2; s++) begin
      out_vld[s]   = (wr_ptr_q[s] != rd_ptr_q[s]);
      head_data[s] = '0;
      head_id[s]   = '0;
      if (out_vld[s]) begin
        head_data[s] = fifo_data_q[s][rd_ptr_q[s][AW-1:0]];
        head_id[s]   = fifo_id_q[s][rd_ptr_q[s][AW-1:0]];
      end
    end
    pop = out_vld & out_rdy;
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    for (int s = 0; s < 2; s++) begin
      cred_d[s]   = cred_q[s] + CW'(inc[s]) - CW'(pop[s]);
      wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
      rd_ptr_d[s] = rd_ptr_q[s] + PW'(pop[s]);
      if (push[s]) begin
        fifo_data_d[s][wr_ptr_q[s][AW-1:0]] = bus.ram_rdata;
        fifo_id_d[s][wr_ptr_q[s][AW-1:0]]   = tag_id_q[RAM_LAT];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      tag_vld_q   <= '0;
      tag_src_q   <= '0;
      for (int k = 0; k <= RAM_LAT; k++) tag_id_q[k] <= '0;
      for (int s = 0; s < 2; s++) begin
        cred_q[s]   <= '0;
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_src_q   <= tag_src_d;
      tag_id_q    <= tag_id_d;
      cred_q      <= cred_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

`ifdef DATARAM_RSP_PARITY_EN
  logic cap_err;
  logic fifo_err_q [2][RSP_DEPTH];
  logic fifo_err_d [2][RSP_DEPTH];
  logic head_err [2];

  // Even parity: a good word has XOR of data and parity bit equal to zero.
  always_comb begin
    cap_err    = (^bus.ram_rdata) ^ bus.ram_rpar;
    fifo_err_d = fifo_err_q;
    for (int s = 0; s < 2; s++) begin
      if (push[s]) fifo_err_d[s][wr_ptr_q[s][AW-1:0]] = cap_err;
      head_err[s] = out_vld[s] & fifo_err_q[s][rd_ptr_q[s][AW-1:0]];
    end
  end

  assign bus.rd_rsp_err = head_err[0];
  assign bus.ev_dat_err = head_err[1];
`endif

  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_id_q   <= fifo_id_d;
`ifdef DATARAM_RSP_PARITY_EN
    fifo_err_q  <= fifo_err_d;
`endif
  end

  assign bus.cmd_rdy     = cmd_rdy;
  assign bus.ram_en      = ram_en_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rd_rsp_vld  = out_vld[0];
  assign bus.rd_rsp_data = head_data[0];
  assign bus.rd_rsp_id   = head_id[0];
  assign bus.ev_dat_vld  = out_vld[1];
  assign bus.ev_dat_data = head_data[1];
  assign bus.ev_dat_id   = head_id[1];

endmodule

// File: tb/tb_dataram_rsp_route.sv
// Randomised and directed bench for dataram_rsp_route: a queue-based model predicts every output each cycle.
// Parity expectations are included when DATARAM_RSP_PARITY_EN is defined.
module tb_dataram_rsp_route;
  localparam int RAM_LAT   = 2;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 256;
  localparam int ID_W      = 6;
  localparam int RSP_DEPTH = 4;
  localparam int NWORDS    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dataram_rsp_route_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  dataram_rsp_route #(
    .RAM_LAT(RAM_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              err;
    int                ready;
  } rsp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  rsp_t rd_q[$];
  rsp_t ev_q[$];
  logic [DATA_W-1:0] exp_mem [NWORDS];
  logic [DATA_W-1:0] ram_mem [NWORDS];
  logic              flip_tbl [NWORDS];
  logic              exp_ram_en, exp_ram_we;
  logic [ADDR_W-1:0] exp_ram_addr;
  logic [DATA_W-1:0] exp_ram_wdata;

  function automatic logic [DATA_W-1:0] initWord(input int a);
    return {8{32'hA500_0000 | 32'(a)}};
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVal(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Environment RAM: RAM_LAT cycles from an enabled read to ram_rdata; junk when not reading.
  logic [DATA_W-1:0] rd_pipe [RAM_LAT];
  logic              par_pipe [RAM_LAT];
  always @(posedge clk) begin
    if (bus.ram_en && bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_en && !bus.ram_we) rd_pipe[0] <= ram_mem[bus.ram_addr];
    else rd_pipe[0] <= {8{$urandom()}};
    par_pipe[0] <= flip_tbl[bus.ram_addr];
    for (int k = 1; k < RAM_LAT; k++) begin
      rd_pipe[k]  <= rd_pipe[k-1];
      par_pipe[k] <= par_pipe[k-1];
    end
  end
  assign bus.ram_rdata = rd_pipe[RAM_LAT-1];
`ifdef DATARAM_RSP_PARITY_EN
  assign bus.ram_rpar = (^rd_pipe[RAM_LAT-1]) ^ par_pipe[RAM_LAT-1];
`endif

  // Model: each accepted read becomes a queue entry visible RAM_LAT+1 edges after its accept edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q.delete();
      ev_q.delete();
      exp_ram_en    = 1'b0;
      exp_ram_we    = 1'b0;
      exp_ram_addr  = '0;
      exp_ram_wdata = '0;
      cyc           = 0;
    end else begin
      logic acc;
      logic rdy_now;
      rsp_t e;
      cyc++;
      rdy_now = bus.cmd_wr || ((bus.cmd_src ? ev_q.size() : rd_q.size()) < RSP_DEPTH);
      acc     = bus.cmd_vld && rdy_now;
      if (rd_q.size() > 0 && rd_q[0].ready < cyc && bus.rd_rsp_rdy) void'(rd_q.pop_front());
      if (ev_q.size() > 0 && ev_q[0].ready < cyc && bus.ev_dat_rdy) void'(ev_q.pop_front());
      exp_ram_en = acc;
      exp_ram_we = acc && bus.cmd_wr;
      if (acc) begin
        exp_ram_addr  = bus.cmd_addr;
        exp_ram_wdata = bus.cmd_wdata;
        if (bus.cmd_wr) begin
          exp_mem[bus.cmd_addr] = bus.cmd_wdata;
        end else begin
          e.id    = bus.cmd_id;
          e.data  = exp_mem[bus.cmd_addr];
          e.err   = flip_tbl[bus.cmd_addr];
          e.ready = cyc + RAM_LAT + 1;
          if (bus.cmd_src) ev_q.push_back(e);
          else rd_q.push_back(e);
        end
      end
    end
  end

  task automatic checkOutput();
    logic exp_rdy, rv, ev;
    logic [DATA_W-1:0] rd_d, ev_d;
    logic [ID_W-1:0] rd_i, ev_i;
    logic rd_e, ev_e;
    exp_rdy = bus.cmd_wr || ((bus.cmd_src ? ev_q.size() : rd_q.size()) < RSP_DEPTH);
    rv = 1'b0; ev = 1'b0; rd_d = '0; ev_d = '0; rd_i = '0; ev_i = '0; rd_e = 1'b0; ev_e = 1'b0;
    if (rd_q.size() > 0 && rd_q[0].ready <= cyc) begin
      rv = 1'b1; rd_d = rd_q[0].data; rd_i = rd_q[0].id; rd_e = rd_q[0].err;
    end
    if (ev_q.size() > 0 && ev_q[0].ready <= cyc) begin
      ev = 1'b1; ev_d = ev_q[0].data; ev_i = ev_q[0].id; ev_e = ev_q[0].err;
    end
    checkBit("cmd_rdy", bus.cmd_rdy, exp_rdy);
    checkBit("ram_en", bus.ram_en, exp_ram_en);
    checkBit("ram_we", bus.ram_we, exp_ram_we);
    checkVal("ram_addr", DATA_W'(bus.ram_addr), DATA_W'(exp_ram_addr));
    checkVal("ram_wdata", bus.ram_wdata, exp_ram_wdata);
    checkBit("rd_rsp_vld", bus.rd_rsp_vld, rv);
    checkVal("rd_rsp_data", bus.rd_rsp_data, rd_d);
    checkVal("rd_rsp_id", DATA_W'(bus.rd_rsp_id), DATA_W'(rd_i));
    checkBit("ev_dat_vld", bus.ev_dat_vld, ev);
    checkVal("ev_dat_data", bus.ev_dat_data, ev_d);
    checkVal("ev_dat_id", DATA_W'(bus.ev_dat_id), DATA_W'(ev_i));
`ifdef DATARAM_RSP_PARITY_EN
    checkBit("rd_rsp_err", bus.rd_rsp_err, rd_e);
    checkBit("ev_dat_err", bus.ev_dat_err, ev_e);
`endif
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  task automatic applyStimulus(input logic vld, input logic wr, input logic src, input logic [ID_W-1:0] id,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                               input logic rr, input logic er);
    bus.cmd_vld    = vld;
    bus.cmd_wr     = wr;
    bus.cmd_src    = src;
    bus.cmd_id     = id;
    bus.cmd_addr   = addr;
    bus.cmd_wdata  = wd;
    bus.rd_rsp_rdy = rr;
    bus.ev_dat_rdy = er;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, b1;
    for (int a = 0; a < NWORDS; a++) begin
      exp_mem[a]  = initWord(a);
      ram_mem[a]  = initWord(a);
      flip_tbl[a] = ($urandom_range(0, 7) == 0);
    end
    for (int k = 0; k < RAM_LAT; k++) begin
      rd_pipe[k]  = '0;
      par_pipe[k] = 1'b0;
    end
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checkBit("rst_cmd_rdy", bus.cmd_rdy, 1'b1);
    checkBit("rst_ram_en", bus.ram_en, 1'b0);
    checkVal("rst_ram_addr", DATA_W'(bus.ram_addr), '0);
    checkVal("rst_ram_wdata", bus.ram_wdata, '0);
    checkBit("rst_rd_vld", bus.rd_rsp_vld, 1'b0);
    checkVal("rst_rd_data", bus.rd_rsp_data, '0);
    rst = 1'b0;
    chk_en = 1'b1;
    stepCycle();

    // Single read to read-return.
    applyStimulus(1, 0, 0, 6'd5, 10'h12, '0, 1, 0);
    #1 checkBit("t1_cmd_rdy", bus.cmd_rdy, 1'b1);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 0);
    #1;
    checkBit("t1_ram_en", bus.ram_en, 1'b1);
    checkVal("t1_ram_addr", DATA_W'(bus.ram_addr), 256'h12);
    checkBit("t1_vld_c1", bus.rd_rsp_vld, 1'b0);
    stepCycle();
    checkBit("t1_ram_en_off", bus.ram_en, 1'b0);
    checkBit("t1_vld_c2", bus.rd_rsp_vld, 1'b0);
    stepCycle();
    checkBit("t1_vld_c3", bus.rd_rsp_vld, 1'b0);
    stepCycle();
    checkBit("t1_vld_c4", bus.rd_rsp_vld, 1'b1);
    checkVal("t1_id", DATA_W'(bus.rd_rsp_id), 256'd5);
    checkVal("t1_data", bus.rd_rsp_data, {8{32'hA500_0012}});
    checkBit("t1_ev_vld", bus.ev_dat_vld, 1'b0);
    stepCycle();

    // Six reads to evict with evict back-pressure: only four fit.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 1, 6'(10 + i), 10'(64 + i), '0, 1, 0);
      #1 checkBit($sformatf("t2_cmd_rdy_%0d", i), bus.cmd_rdy, (i < 4));
      stepCycle();
    end
    applyStimulus(1, 0, 1, 6'd14, 10'd68, '0, 1, 1);
    #1;
    checkBit("t2_rdy_before_pop", bus.cmd_rdy, 1'b0);
    checkBit("t2_ev_vld", bus.ev_dat_vld, 1'b1);
    checkVal("t2_ev_id", DATA_W'(bus.ev_dat_id), 256'd10);
    stepCycle();
    applyStimulus(1, 0, 1, 6'd14, 10'd68, '0, 1, 0);
    #1 checkBit("t2_rdy_after_pop", bus.cmd_rdy, 1'b1);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    repeat (12) stepCycle();

    // Both destinations full, then a write still goes through.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, (i >= 4), 6'(20 + i), 10'(100 + i), '0, 0, 0);
      stepCycle();
    end
    applyStimulus(1, 0, 0, 6'd30, 10'd5, '0, 0, 0);
    #1 checkBit("t3_rd_blocked", bus.cmd_rdy, 1'b0);
    applyStimulus(1, 1, 0, 6'd0, 10'h20, {8{32'hDEAD_BEEF}}, 0, 0);
    #1 checkBit("t3_wr_rdy", bus.cmd_rdy, 1'b1);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
    #1;
    checkBit("t3_ram_we", bus.ram_we, 1'b1);
    checkVal("t3_ram_wdata", bus.ram_wdata, {8{32'hDEAD_BEEF}});
    stepCycle();
    checkBit("t3_ram_we_off", bus.ram_we, 1'b0);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    repeat (12) stepCycle();

    // Reset with one buffered response and two reads in flight.
    applyStimulus(1, 0, 0, 6'd1, 10'd7, '0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
    repeat (3) stepCycle();
    applyStimulus(1, 0, 1, 6'd2, 10'd8, '0, 0, 0);
    stepCycle();
    applyStimulus(1, 0, 0, 6'd3, 10'd9, '0, 0, 0);
    stepCycle();
    applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
    #1 checkBit("t5_buffered", bus.rd_rsp_vld, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkBit("t5_rd_vld", bus.rd_rsp_vld, 1'b0);
    checkBit("t5_ev_vld", bus.ev_dat_vld, 1'b0);
    checkBit("t5_ram_en", bus.ram_en, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkBit($sformatf("t5_no_rd_%0d", i), bus.rd_rsp_vld, 1'b0);
      checkBit($sformatf("t5_no_ev_%0d", i), bus.ev_dat_vld, 1'b0);
    end
    applyStimulus(1, 0, 1, 6'd0, 10'd0, '0, 1, 1);
    #1 checkBit("t5_cred_ev", bus.cmd_rdy, 1'b1);
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    stepCycle();

    // Random traffic with shifting back-pressure.
    b0 = 100;
    b1 = 100;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) begin
        b0 = $urandom_range(0, 100);
        b1 = $urandom_range(0, 100);
      end
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    6'($urandom()), 10'($urandom_range(0, 31)), {8{$urandom()}},
                    ($urandom_range(0, 99) < b0), ($urandom_range(0, 99) < b1));
      stepCycle();
    end
    applyStimulus(0, 0, 0, '0, '0, '0, 1, 1);
    repeat (20) stepCycle();
    checks++;
    if (rd_q.size() != 0 || ev_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d/%0d responses left expected 0/0", rd_q.size(), ev_q.size());
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
